// File: rtl/dm_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and constants.
package dm_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  // Low address bits that must be zero for a word-aligned access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dm_word_array.sv
// Word-wide storage with a synchronous write port and a registered read port.
// Storage is deliberately not reset; only the read register is.
module dm_word_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned IDX_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Store write on the access edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register: loads storage, clears for stores/errors, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (clr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, performs
// it LATENCY edges after acceptance and stalls the CPU until the response.
module dm_responder
  import dm_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int unsigned WORD_W  = ADDR_W - 2;
  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Out-of-range LATENCY is clamped into 1..LATENCY_MAX.
  localparam int unsigned LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                                    ((LATENCY < 1) ? 1 : LATENCY);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LAT_EFF - 1);
  localparam logic [WORD_W-1:0] WORD_LIM = WORD_W'(DEPTH_WORDS);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q;
  logic              err_q;
  logic [IDX_W-1:0]  word_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_err_q;

  logic [WORD_W-1:0] req_word;
  logic              req_err;
  logic              accept;
  logic              access;

  assign req_word = req_addr[ADDR_W-1:2];
  assign req_err  = ((req_addr[1:0] & ALIGN_MASK) != 2'b00) || (req_word >= WORD_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and strobe decode from the current state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    stall     = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        accept    = req_valid;
      end
      ST_BUSY: begin
        stall  = 1'b1;
        access = (cnt_q == '0);
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Latency down-counter: loaded on acceptance, decremented while busy.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = CNT_INIT;
    end else if (state_q == ST_BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Request latch and counter; inputs are only sampled at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        word_q  <= req_addr[IDX_W+1:2];
        wdata_q <= req_wdata;
      end
    end
  end

  // Error flag updates only on the access edge and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (access) begin
      rsp_err_q <= err_q;
    end
  end

  assign rsp_err = rsp_err_q;

  dm_word_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (access && write_q && !err_q),
    .waddr (word_q),
    .wdata (wdata_q),
    .re    (access && !write_q && !err_q),
    .clr   (access && (write_q || err_q)),
    .raddr (word_q),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances at LATENCY 2, 1 and 4.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        stall     [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    dm_responder #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH_WORDS (32),
      .LATENCY     (LAT)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .stall     (stall[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled while busy to prove they are latched.
  task automatic run_req(input int u, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat,
                         input logic [31:0] exp_rd, input bit exp_err, input string nm);
    @(negedge clk);
    req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = addr; req_wdata[u] = wd;
    #1;
    chk({nm, ".req_ready_idle"}, 32'(req_ready[u]), 32'd1);
    chk({nm, ".stall_req"}, 32'(stall[u]), 32'd1);
    @(posedge clk);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      req_valid[u] = 1'b0; req_write[u] = ~wr;
      req_addr[u] = addr ^ 32'h0000_0004; req_wdata[u] = ~wd;
      #1;
      chk($sformatf("%s.busy%0d_ready", nm, k), 32'(req_ready[u]), 32'd0);
      chk($sformatf("%s.busy%0d_stall", nm, k), 32'(stall[u]), 32'd1);
      chk($sformatf("%s.busy%0d_rsp_valid", nm, k), 32'(rsp_valid[u]), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({nm, ".rsp_valid"}, 32'(rsp_valid[u]), 32'd1);
    chk({nm, ".rsp_rdata"}, rsp_rdata[u], exp_rd);
    chk({nm, ".rsp_err"}, 32'(rsp_err[u]), 32'(exp_err));
    chk({nm, ".resp_ready"}, 32'(req_ready[u]), 32'd0);
    chk({nm, ".resp_stall"}, 32'(stall[u]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".after_rsp_valid"}, 32'(rsp_valid[u]), 32'd0);
    chk({nm, ".after_rdata_hold"}, rsp_rdata[u], exp_rd);
    chk({nm, ".after_err_hold"}, 32'(rsp_err[u]), 32'(exp_err));
    chk({nm, ".after_ready"}, 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    #1;
    chk("reset.ready", 32'(req_ready[0]), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset.rdata", rsp_rdata[0], 32'd0);
    chk("reset.err", 32'(rsp_err[0]), 32'd0);
    chk("reset.stall", 32'(stall[0]), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // LATENCY=2: store/load, misaligned store, out-of-range accesses.
    run_req(0, 1'b1, 32'h8,  32'hDEAD_BEEF, 2, 32'h0,         1'b0, "l2_st8");
    run_req(0, 1'b0, 32'h8,  32'h0,         2, 32'hDEAD_BEEF, 1'b0, "l2_ld8");
    run_req(0, 1'b1, 32'h4,  32'h1111_2222, 2, 32'h0,         1'b0, "l2_st4");
    run_req(0, 1'b1, 32'h6,  32'h1234_5678, 2, 32'h0,         1'b1, "l2_st6_mis");
    run_req(0, 1'b0, 32'h4,  32'h0,         2, 32'h1111_2222, 1'b0, "l2_ld4_a");
    run_req(0, 1'b0, 32'h80, 32'h0,         2, 32'h0,         1'b1, "l2_ld80_oor");
    run_req(0, 1'b1, 32'h84, 32'hCAFE_F00D, 2, 32'h0,         1'b1, "l2_st84_oor");
    run_req(0, 1'b0, 32'h4,  32'h0,         2, 32'h1111_2222, 1'b0, "l2_ld4_b");
    run_req(0, 1'b0, 32'h8,  32'h0,         2, 32'hDEAD_BEEF, 1'b0, "l2_ld8_b");

    // LATENCY=1: preload, then back-to-back loads with req_valid held.
    run_req(1, 1'b1, 32'h0, 32'h0000_A0A0, 1, 32'h0, 1'b0, "l1_st0");
    run_req(1, 1'b1, 32'h4, 32'h0000_B1B1, 1, 32'h0, 1'b0, "l1_st4");
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.busy1_ready", 32'(req_ready[1]), 32'd0);
    chk("b2b.busy1_stall", 32'(stall[1]), 32'd1);
    req_addr[1] = 32'h4;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.rsp1_valid", 32'(rsp_valid[1]), 32'd1);
    chk("b2b.rsp1_rdata", rsp_rdata[1], 32'h0000_A0A0);
    chk("b2b.rsp1_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.idle_ready", 32'(req_ready[1]), 32'd1);
    chk("b2b.idle_stall", 32'(stall[1]), 32'd1);
    chk("b2b.idle_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.busy2_ready", 32'(req_ready[1]), 32'd0);
    chk("b2b.busy2_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b.rsp2_valid", 32'(rsp_valid[1]), 32'd1);
    chk("b2b.rsp2_rdata", rsp_rdata[1], 32'h0000_B1B1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b.after_rsp_valid", 32'(rsp_valid[1]), 32'd0);

    // LATENCY=4: reset in the middle of a store discards it.
    run_req(2, 1'b1, 32'hC, 32'h0000_0077, 4, 32'h0,         1'b0, "l4_st77");
    run_req(2, 1'b0, 32'hC, 32'h0,         4, 32'h0000_0077, 1'b0, "l4_ld77");
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'hC; req_wdata[2] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    chk("rst.ready", 32'(req_ready[2]), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("rst.rdata", rsp_rdata[2], 32'd0);
    chk("rst.err", 32'(rsp_err[2]), 32'd0);
    chk("rst.stall_lo", 32'(stall[2]), 32'd0);
    req_valid[2] = 1'b1;
    #1;
    chk("rst.stall_hi", 32'(stall[2]), 32'd1);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.post_ready", 32'(req_ready[2]), 32'd1);
    chk("rst.post_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    run_req(2, 1'b0, 32'hC, 32'h0, 4, 32'h0000_0077, 1'b0, "l4_ld_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder at the far end of the CPU MEM-stage load/store interface.
- Accepts one load or store request at a time from the pipelined CPU.
- Services each request against internal word storage after a programmable latency.
- Drives a stall back to the CPU until the response is delivered, so the pipeline freezes for slow memory instead of assuming single-cycle DM.

Parameters:
- ADDR_W, 32, request address width (byte address)
- DATA_W, 32, data word width
- DEPTH_WORDS, 32, number of words of storage
- LATENCY, 2, rising edges from acceptance to access; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage holds a load or store
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data (forwarded Rt data)
- req_ready  out  1  responder can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid
- rsp_err  out  1  misaligned or out-of-range access, valid with rsp_valid
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle

Behaviour:
- Interface: one clock `clk`, asynchronous active-low reset `rst_n`. These are fixed.
- States:
  - IDLE: req_ready=1.
  - BUSY: req_ready=0, down-counter cnt[3:0] active.
  - RESP: req_ready=0, rsp_valid=1.
- Acceptance occurs on a rising edge when state=IDLE and req_valid=1. On acceptance:
  - Latch req_write, req_addr, req_wdata.
  - Latch err = (req_addr[1:0]!=0) or (req_addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - Load cnt = LATENCY-1 and go to BUSY.
- BUSY transitions:
  - cnt!=0: decrement, stay in BUSY.
  - cnt==0: perform the access on this edge and go to RESP.
    - Store without err: storage[word] <= latched wdata.
    - Load without err: rsp_rdata <= storage[word].
    - Store, or any err: rsp_rdata <= 0.
  - rsp_err <= latched err.
- RESP lasts exactly one cycle, then returns to IDLE. The next request is accepted no earlier than the edge after that IDLE cycle begins.
- Latency: rsp_valid is high in the cycle following the LATENCY-th rising edge after the acceptance edge. Minimum turnaround is LATENCY+2 cycles per request.
- stall = (state==BUSY) or (state==IDLE and req_valid). Stall deasserts in RESP so the pipeline advances on the edge that ends RESP. In that cycle the CPU captures rsp_rdata into MEM/WB.
- Request inputs are sampled only at acceptance. Changes while in BUSY or RESP are ignored.
- Errors: a store with err is suppressed and storage is unchanged. A load with err returns 0. rsp_err has no other side effect.
- Word index = req_addr[ADDR_W-1:2]. Storage is word-wide with no byte enables.
- Reset (asynchronous, any state):
  - State goes to IDLE, cnt=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
  - stall follows req_valid.
  - A store in flight that has not reached its access edge is discarded.
  - Storage contents are not reset.
- rsp_rdata holds its value after RESP until the next access edge. rsp_err likewise holds until the next access edge.

Decomposition:
- Shared package dm_if_pkg:
  - State encoding: IDLE=2'b00, BUSY=2'b01, RESP=2'b10.
  - LATENCY_MAX=15.
  - Address-alignment mask constant.
- Sub-module dm_word_array:
  - DEPTH_WORDS x DATA_W storage.
  - Synchronous write port (we, waddr, wdata) and registered read port.
  - Instantiated once.
- FSM and counter stay in dm_responder.

Test Plan:
- LATENCY=2. Store 0xDEADBEEF to 0x8. Required: stall high from the request cycle through BUSY; rsp_valid one cycle, 2 edges after acceptance; rsp_err=0, rsp_rdata=0. Then load 0x8 -> rsp_rdata=0xDEADBEEF.
- LATENCY=1. Back-to-back load 0x0 then load 0x4, with req_valid held continuously. Required: each response 1 edge after its acceptance; second acceptance exactly 3 edges after the first; req_ready=0 during BUSY and RESP.
- Misaligned store to 0x6 with data 0x12345678. Required: rsp_err=1, rsp_rdata=0. Subsequent load 0x4 returns the prior contents, unchanged.
- Out-of-range load from 0x80 (DEPTH_WORDS=32). Required: rsp_err=1, rsp_rdata=0.
- LATENCY=4. Store 0x55 to 0xC; pull rst_n low at acceptance+2 edges, release after 1 cycle. Required: outputs immediately at reset values, state IDLE; load 0xC returns the old value, not 0x55.
- Change req_addr and req_wdata while BUSY. Required: the access uses the values latched at acceptance.
